// File: rtl/tmr_fault_injector.sv
// Single-event-upset injector for a triplicated datapath: schedules one XOR flip on a chosen
// replica, watches the replicas and the voter, and reports whether the upset was masked.
module tmr_fault_injector #(
  parameter int          DATA_WIDTH = 32,
  parameter int          WAIT_WIDTH = 16,
  parameter int          OBS_CYCLES = 8,
  parameter logic [31:0] SEED       = 32'hACE12468
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [1:0]            target_i,
  input  logic [4:0]            bit_i,
  input  logic [WAIT_WIDTH-1:0] delay_i,
  input  logic [7:0]            duration_i,
  input  logic [DATA_WIDTH-1:0] result_A_i,
  input  logic [DATA_WIDTH-1:0] result_B_i,
  input  logic [DATA_WIDTH-1:0] result_C_i,
  input  logic [DATA_WIDTH-1:0] result_voted_i,
  output logic [DATA_WIDTH-1:0] flip_A_o,
  output logic [DATA_WIDTH-1:0] flip_B_o,
  output logic [DATA_WIDTH-1:0] flip_C_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  masked_o,
  output logic [15:0]           mismatch_count_o,
  output logic [15:0]           inject_count_o
);

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int OBS_W  = $clog2(OBS_CYCLES + 1);
  localparam int CNT_A  = (WAIT_WIDTH > 8) ? WAIT_WIDTH : 8;
  localparam int CNT_W  = (OBS_W > CNT_A) ? OBS_W : CNT_A;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_INJECT  = 3'd2,
    S_OBSERVE = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  state_t                state_r, state_next_s;
  logic [31:0]           lfsr_r, lfsr_next_s;
  logic [CNT_W-1:0]      cnt_r, cnt_next_s;
  logic [1:0]            target_r, cfg_target_s;
  logic [4:0]            bit_r, cfg_bit_s;
  logic [7:0]            dur_r, cfg_dur_s;
  logic [WAIT_WIDTH-1:0] cfg_delay_s;
  logic                  accept_s;
  logic                  masked_acc_r;
  logic [15:0]           mismatch_r, inject_r;
  logic [DATA_WIDTH-1:0] flip_a_r, flip_b_r, flip_c_r;
  logic [DATA_WIDTH-1:0] flip_a_next_s, flip_b_next_s, flip_c_next_s, one_hot_s;
  logic                  busy_r, done_r, masked_r;
  logic                  in_window_s, vote_ok_s, disagree_s, to_report_s;
  logic [DATA_WIDTH-1:0] ref_s;

  // Galois LFSR step and configuration source selection (random mode reads the current LFSR)
  always_comb begin
    lfsr_next_s = {1'b0, lfsr_r[31:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 32'h0);
    if (mode_i) begin
      cfg_target_s = (lfsr_r[1:0] == 2'd3) ? 2'd0 : lfsr_r[1:0];
      cfg_bit_s    = lfsr_r[6:2];
      cfg_delay_s  = lfsr_r[WAIT_WIDTH+6:7] & WAIT_WIDTH'(16'h00FF);
      cfg_dur_s    = 8'd1;
    end else begin
      cfg_target_s = target_i;
      cfg_bit_s    = bit_i;
      cfg_delay_s  = delay_i;
      cfg_dur_s    = (duration_i == 8'd0) ? 8'd1 : duration_i;
    end
  end

  // Next-state and shared phase counter
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          accept_s     = 1'b1;
          state_next_s = S_WAIT;
          cnt_next_s   = CNT_W'(cfg_delay_s);
        end else begin
          cnt_next_s   = {CNT_W{1'b0}};
        end
      end
      S_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = S_INJECT;
          cnt_next_s   = CNT_W'(dur_r - 8'd1);
        end else begin
          cnt_next_s   = cnt_r - CNT_W'(1);
        end
      end
      S_INJECT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = S_OBSERVE;
          cnt_next_s   = CNT_W'(OBS_CYCLES - 1);
        end else begin
          cnt_next_s   = cnt_r - CNT_W'(1);
        end
      end
      S_OBSERVE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = S_REPORT;
        end else begin
          cnt_next_s   = cnt_r - CNT_W'(1);
        end
      end
      S_REPORT: state_next_s = S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // Flip masks for the coming cycle plus per-cycle classification terms
  always_comb begin
    // Shifting past the top bit yields zero, which covers bit indices beyond DATA_WIDTH
    one_hot_s     = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << bit_r;
    flip_a_next_s = {DATA_WIDTH{1'b0}};
    flip_b_next_s = {DATA_WIDTH{1'b0}};
    flip_c_next_s = {DATA_WIDTH{1'b0}};
    if (state_next_s == S_INJECT) begin
      case (target_r)
        2'd0:    flip_a_next_s = one_hot_s;
        2'd1:    flip_b_next_s = one_hot_s;
        2'd2:    flip_c_next_s = one_hot_s;
        default: flip_a_next_s = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      flip_a_next_s = {DATA_WIDTH{1'b0}};
    end
    ref_s       = (target_r == 2'd0) ? result_B_i : result_A_i;
    vote_ok_s   = (result_voted_i == ref_s);
    disagree_s  = !((result_A_i == result_B_i) && (result_B_i == result_C_i));
    in_window_s = (state_r == S_INJECT) || (state_r == S_OBSERVE);
    to_report_s = (state_r == S_OBSERVE) && (state_next_s == S_REPORT);
  end

  // FSM, LFSR and latched injection configuration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      lfsr_r   <= LFSR_INIT;
      cnt_r    <= {CNT_W{1'b0}};
      target_r <= 2'd0;
      bit_r    <= 5'd0;
      dur_r    <= 8'd1;
    end else begin
      state_r <= state_next_s;
      lfsr_r  <= lfsr_next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        target_r <= cfg_target_s;
        bit_r    <= cfg_bit_s;
        dur_r    <= cfg_dur_s;
      end
    end
  end

  // Classification accumulators and saturating counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      masked_acc_r <= 1'b1;
      mismatch_r   <= 16'd0;
      inject_r     <= 16'd0;
      masked_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        masked_acc_r <= 1'b1;
        mismatch_r   <= 16'd0;
      end else if (in_window_s) begin
        masked_acc_r <= masked_acc_r & vote_ok_s;
        if (disagree_s && (mismatch_r != 16'hFFFF)) begin
          mismatch_r <= mismatch_r + 16'd1;
        end
      end
      if (to_report_s) begin
        masked_r <= masked_acc_r & vote_ok_s;
        if (inject_r != 16'hFFFF) begin
          inject_r <= inject_r + 16'd1;
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flip_a_r <= {DATA_WIDTH{1'b0}};
      flip_b_r <= {DATA_WIDTH{1'b0}};
      flip_c_r <= {DATA_WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      flip_a_r <= flip_a_next_s;
      flip_b_r <= flip_b_next_s;
      flip_c_r <= flip_c_next_s;
      busy_r   <= (state_next_s != S_IDLE);
      done_r   <= (state_next_s == S_REPORT);
    end
  end

  assign flip_A_o         = flip_a_r;
  assign flip_B_o         = flip_b_r;
  assign flip_C_o         = flip_c_r;
  assign busy_o           = busy_r;
  assign done_o           = done_r;
  assign masked_o         = masked_r;
  assign mismatch_count_o = mismatch_r;
  assign inject_count_o   = inject_r;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Directed bench for tmr_fault_injector: timing, masks, classification, start hold, random mode, reset.
module tb_tmr_fault_injector;
  localparam int OBS = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0, mode_i = 1'b0;
  logic [1:0]  target_i = 2'd0;
  logic [4:0]  bit_i = 5'd0;
  logic [15:0] delay_i = 16'd0;
  logic [7:0]  duration_i = 8'd0;
  logic [31:0] result_A_i = 32'h1234, result_B_i = 32'h1234, result_C_i = 32'h1234;
  logic [31:0] result_voted_i = 32'h1234;
  logic [31:0] flip_A_o, flip_B_o, flip_C_o;
  logic        busy_o, done_o, masked_o;
  logic [15:0] mismatch_count_o, inject_count_o;

  int n_cmp = 0, n_bad = 0;
  int r_done_n, r_first_n, r_cyc_a, r_cyc_b, r_cyc_c;
  logic [31:0] r_mask_or, lfsr_cap, m_lfsr;

  tmr_fault_injector dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .mode_i(mode_i),
    .target_i(target_i), .bit_i(bit_i), .delay_i(delay_i), .duration_i(duration_i),
    .result_A_i(result_A_i), .result_B_i(result_B_i), .result_C_i(result_C_i),
    .result_voted_i(result_voted_i),
    .flip_A_o(flip_A_o), .flip_B_o(flip_B_o), .flip_C_o(flip_C_o),
    .busy_o(busy_o), .done_o(done_o), .masked_o(masked_o),
    .mismatch_count_o(mismatch_count_o), .inject_count_o(inject_count_o)
  );

  always #5 clk = ~clk;

  // Reference Galois LFSR, right-shifting with taps 32'h80200003
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 32'hACE12468;
    else          m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_inj(input logic md, input logic [1:0] tg, input logic [4:0] bt,
                         input logic [15:0] dl, input logic [7:0] du, input logic corrupt);
    int n;
    @(negedge clk);
    mode_i = md; target_i = tg; bit_i = bt; delay_i = dl; duration_i = du; start_i = 1'b1;
    lfsr_cap = m_lfsr;
    n = 0; r_done_n = 0; r_first_n = 0; r_cyc_a = 0; r_cyc_b = 0; r_cyc_c = 0; r_mask_or = 32'h0;
    while (r_done_n == 0 && n < 400) begin
      @(negedge clk);
      start_i = 1'b0;
      n++;
      if (flip_A_o != 32'h0) r_cyc_a++;
      if (flip_B_o != 32'h0) r_cyc_b++;
      if (flip_C_o != 32'h0) r_cyc_c++;
      if (((flip_A_o | flip_B_o | flip_C_o) != 32'h0) && r_first_n == 0) r_first_n = n;
      r_mask_or |= flip_A_o | flip_B_o | flip_C_o;
      if (corrupt && flip_B_o != 32'h0) begin
        result_voted_i = 32'h1244; result_B_i = 32'h1224;
      end else begin
        result_voted_i = 32'h1234; result_B_i = 32'h1234;
      end
      if (done_o) r_done_n = n;
    end
    if (r_done_n == 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int pulses;
    logic [15:0] ic0;
    logic [1:0]  e_tg;
    logic [4:0]  e_bt;
    logic [15:0] e_dl;
    logic [31:0] ones_hot;

    repeat (3) @(negedge clk);
    check_eq("rst_flipA", flip_A_o, 32'h0);
    check_eq("rst_flipB", flip_B_o, 32'h0);
    check_eq("rst_flipC", flip_C_o, 32'h0);
    check_eq("rst_flags", {busy_o, done_o, masked_o}, 32'h0);
    check_eq("rst_counts", {mismatch_count_o, inject_count_o}, 32'h0);
    reset_n = 1'b1;

    // directed B, bit 4, delay 3, duration 2
    run_inj(1'b0, 2'd1, 5'd4, 16'd3, 8'd2, 1'b0);
    check_eq("d1_done_n", r_done_n, 32'd15);
    check_eq("d1_first_n", r_first_n, 32'd5);
    check_eq("d1_cyc_b", r_cyc_b, 32'd2);
    check_eq("d1_cyc_ac", r_cyc_a + r_cyc_c, 32'd0);
    check_eq("d1_mask", r_mask_or, 32'h10);
    check_eq("d1_masked", masked_o, 32'd1);
    check_eq("d1_busy", busy_o, 32'd1);
    check_eq("d1_icnt", inject_count_o, 32'd1);
    check_eq("d1_mcnt", mismatch_count_o, 32'd0);
    @(negedge clk);
    check_eq("d1_done_pulse", done_o, 32'd0);
    check_eq("d1_busy_off", busy_o, 32'd0);

    // same, voter and replica B corrupted during INJECT
    run_inj(1'b0, 2'd1, 5'd4, 16'd3, 8'd2, 1'b1);
    check_eq("d2_masked", masked_o, 32'd0);
    check_eq("d2_mcnt", mismatch_count_o, 32'd2);
    check_eq("d2_icnt", inject_count_o, 32'd2);
    @(negedge clk);
    check_eq("d2_masked_hold", masked_o, 32'd0);

    // golden run, delay 0
    run_inj(1'b0, 2'd3, 5'd9, 16'd0, 8'd1, 1'b0);
    check_eq("g_done_n", r_done_n, 32'd11);
    check_eq("g_mask", r_mask_or, 32'h0);
    check_eq("g_masked", masked_o, 32'd1);
    check_eq("g_mcnt", mismatch_count_o, 32'd0);

    // duration 0 acts as 1, top bit of A
    run_inj(1'b0, 2'd0, 5'd31, 16'd1, 8'd0, 1'b0);
    check_eq("z_done_n", r_done_n, 32'd12);
    check_eq("z_first_n", r_first_n, 32'd3);
    check_eq("z_cyc_a", r_cyc_a, 32'd1);
    check_eq("z_mask", r_mask_or, 32'h80000000);
    check_eq("z_icnt", inject_count_o, 32'd4);

    // start held high for 40 cycles
    @(negedge clk);
    ic0 = inject_count_o;
    mode_i = 1'b0; target_i = 2'd1; bit_i = 5'd0; delay_i = 16'd0; duration_i = 8'd1; start_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    start_i = 1'b0;
    check_eq("hold_window", pulses, 32'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    check_eq("hold_total", pulses, 32'd4);
    check_eq("hold_icnt", inject_count_o - ic0, 32'd4);

    // asynchronous reset in the middle of INJECT
    run_inj(1'b0, 2'd0, 5'd0, 16'd0, 8'd1, 1'b0);
    @(negedge clk);
    mode_i = 1'b0; target_i = 2'd2; bit_i = 5'd7; delay_i = 16'd2; duration_i = 8'd5; start_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50 && flip_C_o == 32'h0; i++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check_eq("r_flipC_pre", flip_C_o, 32'h80);
    #2 reset_n = 1'b0;
    #1;
    check_eq("r_flipC", flip_C_o, 32'h0);
    check_eq("r_flags", {busy_o, done_o, masked_o}, 32'h0);
    check_eq("r_counts", {mismatch_count_o, inject_count_o}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // random mode from the reset seed, twice
    for (int k = 0; k < 2; k++) begin
      run_inj(1'b1, 2'd3, 5'd0, 16'd0, 8'd9, 1'b0);
      e_tg = (lfsr_cap[1:0] == 2'd3) ? 2'd0 : lfsr_cap[1:0];
      e_bt = lfsr_cap[6:2];
      e_dl = lfsr_cap[22:7] & 16'h00FF;
      ones_hot = 32'h1 << e_bt;
      check_eq("rnd_done_n", r_done_n, 32'(e_dl) + 32'd3 + 32'(OBS));
      check_eq("rnd_mask", r_mask_or, ones_hot);
      check_eq("rnd_onehot", $countones(r_mask_or), 32'd1);
      check_eq("rnd_cyc_total", r_cyc_a + r_cyc_b + r_cyc_c, 32'd1);
      check_eq("rnd_target", (e_tg == 2'd0) ? r_cyc_a : (e_tg == 2'd1) ? r_cyc_b : r_cyc_c, 32'd1);
      check_eq("rnd_icnt", inject_count_o, 32'(k + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tmr_fault_injector.md
Name: tmr_fault_injector

Overview:
Fault-injection controller for the triplicated RS5 datapath; it drives the other end of the replica result interface (result_A/B/C, result_voted).
- Generates single-event-upset XOR masks for one chosen replica at a scheduled cycle.
- Observes the three replica results and the voted result, then classifies each injection as masked or not masked.
- Sits beside the RS5 instance in reliability benches and in campaign FPGA builds.

Parameters:
DATA_WIDTH, 32, width of replica results and flip masks
WAIT_WIDTH, 16, width of the pre-injection delay counter
OBS_CYCLES, 8, cycles observed after the flip is removed (>=1)
SEED, 32'hACE12468, LFSR reset value (0 is replaced by 1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_i  in  1  start one injection; sampled only in IDLE
mode_i  in  1  0 = directed (use *_i config), 1 = random (LFSR config)
target_i  in  2  replica to hit: 0=A, 1=B, 2=C, 3=none (golden run)
bit_i  in  5  bit index to flip, 0..DATA_WIDTH-1
delay_i  in  WAIT_WIDTH  cycles from start to first flip cycle
duration_i  in  8  flip length in cycles; 0 is treated as 1
result_A_i / result_B_i / result_C_i  in  DATA_WIDTH  replica results
result_voted_i  in  DATA_WIDTH  voter output
flip_A_o / flip_B_o / flip_C_o  out  DATA_WIDTH  XOR masks into replicas, registered
busy_o  out  1  high from accepted start until REPORT inclusive
done_o  out  1  one-cycle pulse in REPORT
masked_o  out  1  classification of the last injection, held until the next REPORT
mismatch_count_o  out  16  cycles with any replica disagreement in the current injection, saturating
inject_count_o  out  16  completed injections since reset, saturating

Behaviour:
- Reset: all outputs 0. FSM in IDLE. LFSR = SEED (or 1).
- LFSR: 32-bit Galois, taps 32'h80200003, advances every cycle regardless of state.
- IDLE, start_i=1: latch config, clear mismatch_count, go to WAIT. busy_o rises on the next edge.
  - Random mode: target = lfsr[1:0] (3 maps to 0), bit = lfsr[6:2], delay = lfsr[WAIT_WIDTH+6:7] & 16'h00FF, duration = 1.
  - All values are taken from the LFSR as it stood on the start edge.
- start_i outside IDLE is ignored and has no latching side effect.
- WAIT: down-counter loaded with delay. Leave for INJECT on the edge where the counter equals 0. delay=0 gives exactly 1 WAIT cycle.
- INJECT: the target flip mask = 1 << bit for exactly duration cycles. The other masks stay 0. Target 3 keeps all masks 0.
  - The first mask cycle is the first INJECT cycle (mask is registered).
- OBSERVE: all masks 0. Runs exactly OBS_CYCLES cycles, then goes to REPORT.
- Classification, evaluated over INJECT and OBSERVE cycles:
  - ref = the lower-indexed non-target replica (target 0 -> B; target 1 or 2 -> A; target 3 -> A).
  - masked = (result_voted_i == ref) on every such cycle.
  - mismatch_count increments, saturating at 16'hFFFF, on any cycle where A, B and C are not all equal.
- REPORT: one cycle. done_o=1, masked_o updated, inject_count +1 (saturating), busy_o still 1. Then IDLE.
- Done timing: start accepted at edge T gives done_o high during cycle T + 1 + (delay+1) + duration + OBS_CYCLES.
- Asynchronous reset in any state: masks clear immediately and all counters clear. Nothing is reported.
- Width rule: bit_i >= DATA_WIDTH produces an all-zero mask. This matters only when DATA_WIDTH < 32.

Test Plan:
- Directed target=1, bit=4, delay=3, duration=2, replicas stable at 32'h1234 -> flip_B_o = 32'h10 for exactly 2 cycles; masked_o=1; done_o after 1+4+2+8 = 15 cycles; inject_count_o=1.
- Same setup, but the bench corrupts result_voted_i to 32'h1244 during INJECT -> masked_o=0; mismatch_count_o = 2 when the bench also flips result_B_i.
- target=3, delay=0 -> all masks stay 0; exactly 1 WAIT cycle; masked_o=1; mismatch_count_o=0.
- start_i held high for 40 cycles with delay=0, duration=1 -> exactly one injection per IDLE visit; inject_count_o increments by 1 per done_o pulse.
- Random mode from reset with SEED=32'hACE12468 -> target/bit/delay match the reference LFSR model; target is never 3; flip mask is a one-hot value.
- reset_n asserted mid-INJECT -> flip masks go to 0 with no clock edge; busy_o=0; counts=0; the next start behaves as from power-up.
